cpu_dcache_write_buffer: RTL and testbench
==========================================

// Module: cpu_dcache_write_buffer
// PURPOSE
//  Posted-write buffer directly downstream of the data cache bus master port.
//  Absorbs write-backs and uncached writes into a FIFO, acking them without bus latency.
//  Drains the FIFO to the system bus in order. Reads wait for the drain, then pass through.
// PARAMETERS
//  DEPTH_LOG2  2  FIFO depth = 1<<DEPTH_LOG2 entries; each entry holds {address[31:0], wdata[31:0]}.
// PORTS
//  i_clock        in   1   single clock; all state on posedge
//  i_reset        in   1   asynchronous, active-low reset
//  i_rw           in   1   upstream (cache side): 1 = write, 0 = read
//  i_request      in   1   upstream request, held until o_ready
//  o_ready        out  1   upstream ack, one-cycle pulse per transaction
//  i_address      in   32  upstream word address
//  i_wdata        in   32  upstream write data
//  o_rdata        out  32  upstream read data, valid while o_ready is high on a read
//  o_bus_rw       out  1   downstream (system bus) direction
//  o_bus_request  out  1   downstream request
//  i_bus_ready    in   1   downstream ack
//  o_bus_address  out  32  downstream address
//  o_bus_wdata    out  32  downstream write data
//  i_bus_rdata    in   32  downstream read data
//  o_empty        out  1   FIFO empty and no bus write in flight; used by fences/flush
// BEHAVIOUR
//  Reset (i_reset=0, asynchronous): pointers and count go to 0. The bus FSM goes to B_IDLE.
//   o_bus_request, o_bus_rw, o_ready = 0. o_bus_address, o_bus_wdata, o_rdata = 0. o_empty = 1.
//   Buffered writes are discarded. A bus transfer in flight at reset is dropped at once.
//  Upstream handshake: a transaction completes in the cycle o_ready=1.
//   If i_request is high in any later cycle, that is a new transaction,
//   including back-to-back requests with no idle cycle between them.
//  Write accept: if i_request & i_rw & !full (registered count), the buffer pushes in the same cycle
//   and drives o_ready=1 combinationally. Accept latency is 0 cycles.
//   When full, o_ready stays 0. The write is accepted in the first cycle after count drops.
//   Full is evaluated on the registered count only. A pop and a push in the same cycle leave count unchanged.
//  Pointers: DEPTH_LOG2+1 bits with natural wrap. full = MSBs differ and lower bits equal.
//  Bus FSM states: B_IDLE, B_WRITE, B_READ.
//   B_IDLE -> B_WRITE when count != 0. The head entry is registered onto o_bus_*, with o_bus_rw=1.
//   B_IDLE -> B_READ when count == 0 and there is a pending read (i_request & !i_rw).
//   B_WRITE: request, address and data are held stable until i_bus_ready.
//    On i_bus_ready: pop. If count != 1, load the next head and stay in B_WRITE; else go to B_IDLE.
//   B_READ: o_bus_rw=0, o_bus_address=i_address, o_bus_request=1, o_rdata=i_bus_rdata.
//    o_ready=i_bus_ready. On i_bus_ready go to B_IDLE.
//  Ordering: reads never overtake buffered writes. No new write is accepted while in B_READ.
//  A read arriving with count != 0 waits with no o_ready until the drain completes.
//  Minimum read latency from empty: 1 cycle (B_IDLE->B_READ) plus bus latency.
//  o_empty = (count == 0) & (state != B_WRITE).
// CONFIGURATION
//  WBUF_FORWARD_EN defined: a read whose address matches a valid FIFO entry completes with o_ready=1
//   in the same cycle, with no bus access. o_rdata is the youngest matching entry's data.
//   The match uses the pre-pop contents, so an entry popping in that cycle still forwards.
//   Reads with no match still wait for the drain.
//  Undefined: no address compare; every read waits for the drain and goes to the bus.
// STRUCTURE
//  cpu_wbuf_pkg: bus_state_t enum {B_IDLE,B_WRITE,B_READ}; wbuf_entry_t struct {addr,data}.
//  Sub-module cpu_sync_fifo (parameterised width/depth): push/pop/full/empty/count plus head output.
//   The forward compare reads the storage array through a debug tap, enabled only under WBUF_FORWARD_EN.
//  Top level holds the bus FSM, output registers and the forwarding mux.
// TESTING
//  1. Reset then 4 writes (0x100..0x10C, data 0xA0..0xA3), i_bus_ready always 1
//     -> each write gets o_ready in the same cycle; bus sees 4 writes in order; o_empty=1 afterwards.
//  2. Bus stalled (i_bus_ready=0) and 5 writes with DEPTH_LOG2=2
//     -> 4 acks; 5th write waits; it is acked the cycle after the first bus ack.
//  3. 2 buffered writes then read 0x200 (bus returns 0xDEAD)
//     -> bus shows W,W,R in order; o_rdata=0xDEAD with o_ready on the read's bus ack.
//  4. WBUF_FORWARD_EN: write 0x300=0x11, write 0x300=0x22, read 0x300 while the bus stalls
//     -> o_ready=1 in the read cycle with o_rdata=0x22; no bus read is issued.
//  5. i_reset low mid-B_WRITE with 3 entries queued
//     -> o_bus_request=0 immediately; after release o_empty=1 and no further bus writes.
//  6. Back-to-back writes with i_request held high across the o_ready pulse
//     -> two distinct entries are pushed on consecutive cycles.

Source files
------------

// File: rtl/cpu_wbuf_pkg.sv
// Shared types for the data-cache posted-write buffer.
// Optional store-to-load forwarding is enabled with the WBUF_FORWARD_EN macro.
package cpu_wbuf_pkg;

  typedef enum logic [1:0] {
    B_IDLE,
    B_WRITE,
    B_READ
  } bus_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wbuf_entry_t;

  localparam int unsigned ENTRY_W = $bits(wbuf_entry_t);

endpackage

// File: rtl/cpu_sync_fifo.sv
// Synchronous FIFO with head and next-head read ports.
// Defining WBUF_FORWARD_EN exposes the storage array for the forwarding compare.
module cpu_sync_fifo #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [WIDTH-1:0]      head,
  output logic [WIDTH-1:0]      head_next
`ifdef WBUF_FORWARD_EN
  ,
  output logic [(1<<DEPTH_LOG2)*WIDTH-1:0] tap_data,
  output logic [DEPTH_LOG2-1:0]            tap_rd_idx
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] rd_idx_next;
  logic                  push_ok;
  logic                  pop_ok;
  logic [WIDTH-1:0]      mem [DEPTH];

  assign wr_idx      = wr_ptr[DEPTH_LOG2-1:0];
  assign rd_idx      = rd_ptr[DEPTH_LOG2-1:0];
  assign rd_idx_next = rd_idx + 1'b1;

  // Extra pointer bit distinguishes full from empty when the indices coincide
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) && (wr_idx == rd_idx);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_idx] <= wdata;
  end

  assign head      = mem[rd_idx];
  assign head_next = mem[rd_idx_next];

`ifdef WBUF_FORWARD_EN
  always_comb begin
    tap_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      tap_data[i*WIDTH +: WIDTH] = mem[i];
    end
  end

  assign tap_rd_idx = rd_idx;
`endif

endmodule

// File: rtl/cpu_dcache_write_buffer.sv
// Posted-write buffer between the data cache and the system bus; drains writes in order.
// Defining WBUF_FORWARD_EN lets reads hitting a buffered write complete without a bus access.
module cpu_dcache_write_buffer
  import cpu_wbuf_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_rw,
  input  logic        i_request,
  output logic        o_ready,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  output logic        o_empty
);

  localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  bus_state_t        state;
  bus_state_t        state_nxt;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PTR_W-1:0]  count;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ENTRY_W-1:0] fifo_head_next;
  wbuf_entry_t       head_e;
  wbuf_entry_t       head_next_e;
  wbuf_entry_t       push_e;
  logic              load_head;
  logic              load_next;
  logic              read_ready;
  logic [31:0]       bus_addr_q;
  logic [31:0]       bus_data_q;
  logic              fwd_hit;
  logic [31:0]       fwd_data;

  assign push_e.addr = i_address;
  assign push_e.data = i_wdata;
  assign head_e      = fifo_head;
  assign head_next_e = fifo_head_next;

  // Writes are refused during B_READ so a read never completes ahead of a younger write
  assign push = i_reset & i_request & i_rw & ~fifo_full & (state != B_READ);
  assign pop  = (state == B_WRITE) & i_bus_ready;

`ifdef WBUF_FORWARD_EN
  logic [DEPTH*ENTRY_W-1:0] tap_data;
  logic [DEPTH_LOG2-1:0]    tap_rd_idx;
  logic [DEPTH_LOG2-1:0]    fwd_idx;
  wbuf_entry_t              fwd_entry;
  logic                     fwd_match;

  cpu_sync_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk        (i_clock),
    .rst_n      (i_reset),
    .push       (push),
    .pop        (pop),
    .wdata      (push_e),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (count),
    .head       (fifo_head),
    .head_next  (fifo_head_next),
    .tap_data   (tap_data),
    .tap_rd_idx (tap_rd_idx)
  );

  // Walk oldest to youngest so the last match left standing is the youngest write
  always_comb begin
    fwd_match = 1'b0;
    fwd_data  = '0;
    fwd_idx   = '0;
    fwd_entry = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_idx   = tap_rd_idx + DEPTH_LOG2'(k);
      fwd_entry = tap_data[fwd_idx*ENTRY_W +: ENTRY_W];
      if ((PTR_W'(k) < count) && (fwd_entry.addr == i_address)) begin
        fwd_match = 1'b1;
        fwd_data  = fwd_entry.data;
      end
    end
  end

  assign fwd_hit = i_request & ~i_rw & (state != B_READ) & fwd_match;
`else
  cpu_sync_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk        (i_clock),
    .rst_n      (i_reset),
    .push       (push),
    .pop        (pop),
    .wdata      (push_e),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (count),
    .head       (fifo_head),
    .head_next  (fifo_head_next)
  );

  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= B_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_head  = 1'b0;
    load_next  = 1'b0;
    read_ready = 1'b0;
    case (state)
      B_IDLE: begin
        if (count != '0) begin
          state_nxt = B_WRITE;
          load_head = 1'b1;
        end else if (i_request && !i_rw) begin
          state_nxt = B_READ;
        end
      end
      B_WRITE: begin
        if (i_bus_ready) begin
          if (count != PTR_W'(1)) begin
            load_next = 1'b1;
          end else begin
            state_nxt = B_IDLE;
          end
        end
      end
      B_READ: begin
        read_ready = i_bus_ready;
        if (i_bus_ready) state_nxt = B_IDLE;
      end
      default: state_nxt = B_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      bus_addr_q <= '0;
      bus_data_q <= '0;
    end else if (load_head) begin
      bus_addr_q <= head_e.addr;
      bus_data_q <= head_e.data;
    end else if (load_next) begin
      bus_addr_q <= head_next_e.addr;
      bus_data_q <= head_next_e.data;
    end
  end

  assign o_bus_request = (state != B_IDLE);
  assign o_bus_rw      = (state == B_WRITE);
  assign o_bus_address = (state == B_READ) ? i_address : bus_addr_q;
  assign o_bus_wdata   = bus_data_q;

  assign o_ready = push | read_ready | fwd_hit;
  assign o_rdata = (state == B_READ) ? i_bus_rdata :
                   fwd_hit           ? fwd_data    : '0;

  assign o_empty = fifo_empty & (state != B_WRITE);

endmodule

// File: tb/tb_cpu_dcache_write_buffer.sv
// Directed bench for cpu_dcache_write_buffer; forwarding cases run when WBUF_FORWARD_EN is defined.
module tb_cpu_dcache_write_buffer;

  logic        i_clock;
  logic        i_reset;
  logic        i_rw;
  logic        i_request;
  logic        o_ready;
  logic [31:0] i_address;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_bus_rw;
  logic        o_bus_request;
  logic        i_bus_ready;
  logic [31:0] o_bus_address;
  logic [31:0] o_bus_wdata;
  logic [31:0] i_bus_rdata;
  logic        o_empty;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic        req;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        bready;
    logic        exp_ready;
    logic        exp_breq;
    logic        exp_brw;
    logic [31:0] exp_baddr;
    logic [31:0] exp_bwdata;
    logic [31:0] exp_rdata;
    logic        exp_empty;
  } vec_t;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  vec_t  vecs [10];
  xfer_t bus_log [$];

  cpu_dcache_write_buffer #(.DEPTH_LOG2(2)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_rw          (i_rw),
    .i_request     (i_request),
    .o_ready       (o_ready),
    .i_address     (i_address),
    .i_wdata       (i_wdata),
    .o_rdata       (o_rdata),
    .o_bus_rw      (o_bus_rw),
    .o_bus_request (o_bus_request),
    .i_bus_ready   (i_bus_ready),
    .o_bus_address (o_bus_address),
    .o_bus_wdata   (o_bus_wdata),
    .i_bus_rdata   (i_bus_rdata),
    .o_empty       (o_empty)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  always @(negedge i_clock) begin
    if (i_reset && o_bus_request && i_bus_ready)
      bus_log.push_back('{o_bus_rw, o_bus_address, o_bus_rw ? o_bus_wdata : i_bus_rdata});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_xfer(input string nm, input int unsigned i, input logic rw,
                          input logic [31:0] addr, input logic [31:0] data);
    if (i < bus_log.size()) begin
      chk({nm, " rw"}, 32'(bus_log[i].rw), 32'(rw));
      chk({nm, " addr"}, bus_log[i].addr, addr);
      chk({nm, " data"}, bus_log[i].data, data);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: got no transfer expected transfer %0d", nm, i);
    end
  endtask

  task automatic next_cycle();
    @(posedge i_clock);
    #1;
  endtask

  task automatic drive(input logic req, input logic rw, input logic [31:0] addr,
                       input logic [31:0] wdata);
    i_request = req;
    i_rw      = rw;
    i_address = addr;
    i_wdata   = wdata;
  endtask

  task automatic apply_reset();
    next_cycle();
    drive(1'b0, 1'b0, '0, '0);
    i_bus_ready = 1'b0;
    i_reset     = 1'b0;
    next_cycle();
    next_cycle();
    i_reset = 1'b1;
    bus_log.delete();
  endtask

  task automatic drain(input string nm, input int unsigned max_cycles);
    drive(1'b0, 1'b0, '0, '0);
    i_bus_ready = 1'b1;
    for (int unsigned n = 0; n < max_cycles; n++) begin
      @(negedge i_clock);
      if (o_empty) break;
    end
    chk({nm, " drained"}, 32'(o_empty), 32'd1);
  endtask

  initial begin
    drive(1'b0, 1'b0, '0, '0);
    i_bus_ready = 1'b0;
    i_bus_rdata = 32'hDEAD;
    i_reset     = 1'b1;
    #2;
    i_reset = 1'b0;
    drive(1'b1, 1'b1, 32'h55, 32'h66);
    #1;
    chk("reset ready", 32'(o_ready), 32'd0);
    chk("reset bus_req", 32'(o_bus_request), 32'd0);
    chk("reset bus_rw", 32'(o_bus_rw), 32'd0);
    chk("reset bus_addr", o_bus_address, 32'd0);
    chk("reset bus_wdata", o_bus_wdata, 32'd0);
    chk("reset rdata", o_rdata, 32'd0);
    chk("reset empty", 32'(o_empty), 32'd1);
    drive(1'b0, 1'b0, '0, '0);
    next_cycle();
    next_cycle();
    i_reset = 1'b1;
    bus_log.delete();

    // four back-to-back writes, free-running bus, then a read from empty
    vecs[0] = '{1, 1, 32'h100, 32'hA0, 1, 1, 0, 0, 0,      0,     0,        1};
    vecs[1] = '{1, 1, 32'h104, 32'hA1, 1, 1, 0, 0, 0,      0,     0,        0};
    vecs[2] = '{1, 1, 32'h108, 32'hA2, 1, 1, 1, 1, 32'h100, 32'hA0, 0,       0};
    vecs[3] = '{1, 1, 32'h10C, 32'hA3, 1, 1, 1, 1, 32'h104, 32'hA1, 0,       0};
    vecs[4] = '{0, 0, 0,       0,      1, 0, 1, 1, 32'h108, 32'hA2, 0,       0};
    vecs[5] = '{0, 0, 0,       0,      1, 0, 1, 1, 32'h10C, 32'hA3, 0,       0};
    vecs[6] = '{0, 0, 0,       0,      1, 0, 0, 0, 0,      0,     0,        1};
    vecs[7] = '{1, 0, 32'h200, 0,      1, 0, 0, 0, 0,      0,     0,        1};
    vecs[8] = '{1, 0, 32'h200, 0,      1, 1, 1, 0, 32'h200, 0,     32'hDEAD, 1};
    vecs[9] = '{0, 0, 0,       0,      1, 0, 0, 0, 0,      0,     0,        1};

    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive(vecs[i].req, vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      i_bus_ready = vecs[i].bready;
      @(negedge i_clock);
      chk($sformatf("vec%0d ready", i), 32'(o_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d bus_req", i), 32'(o_bus_request), 32'(vecs[i].exp_breq));
      chk($sformatf("vec%0d empty", i), 32'(o_empty), 32'(vecs[i].exp_empty));
      if (vecs[i].exp_breq) begin
        chk($sformatf("vec%0d bus_rw", i), 32'(o_bus_rw), 32'(vecs[i].exp_brw));
        chk($sformatf("vec%0d bus_addr", i), o_bus_address, vecs[i].exp_baddr);
        if (vecs[i].exp_brw)
          chk($sformatf("vec%0d bus_wdata", i), o_bus_wdata, vecs[i].exp_bwdata);
      end
      if (vecs[i].exp_ready && !vecs[i].rw)
        chk($sformatf("vec%0d rdata", i), o_rdata, vecs[i].exp_rdata);
    end
    chk("t1 log size", bus_log.size(), 32'd5);
    for (int unsigned i = 0; i < 4; i++)
      chk_xfer($sformatf("t1 xfer%0d", i), i, 1'b1, 32'h100 + 4*i, 32'hA0 + i);
    chk_xfer("t1 read", 4, 1'b0, 32'h200, 32'hDEAD);

    // stalled bus: fifth write waits for room, acked the cycle after the first bus ack
    apply_reset();
    for (int unsigned i = 0; i < 4; i++) begin
      next_cycle();
      drive(1'b1, 1'b1, 32'h400 + 4*i, 32'hB0 + i);
      @(negedge i_clock);
      chk($sformatf("t2 ack%0d", i), 32'(o_ready), 32'd1);
    end
    next_cycle();
    drive(1'b1, 1'b1, 32'h410, 32'hB4);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge i_clock);
      chk($sformatf("t2 full wait%0d", i), 32'(o_ready), 32'd0);
      chk($sformatf("t2 hold addr%0d", i), o_bus_address, 32'h400);
      next_cycle();
    end
    i_bus_ready = 1'b1;
    @(negedge i_clock);
    chk("t2 ready during bus ack", 32'(o_ready), 32'd0);
    next_cycle();
    i_bus_ready = 1'b0;
    @(negedge i_clock);
    chk("t2 fifth ack", 32'(o_ready), 32'd1);
    chk("t2 next head", o_bus_address, 32'h404);
    next_cycle();
    drain("t2", 40);
    chk("t2 log size", bus_log.size(), 32'd5);
    for (int unsigned i = 0; i < 5; i++)
      chk_xfer($sformatf("t2 xfer%0d", i), i, 1'b1, 32'h400 + 4*i, 32'hB0 + i);

    // read behind two buffered writes
    apply_reset();
    i_bus_ready = 1'b1;
    next_cycle();
    drive(1'b1, 1'b1, 32'h500, 32'hC0);
    next_cycle();
    drive(1'b1, 1'b1, 32'h504, 32'hC1);
    next_cycle();
    drive(1'b1, 1'b0, 32'h200, 32'h0);
    begin
      int unsigned lat;
      logic        seen;
      seen = 1'b0;
      lat  = 0;
      for (int unsigned n = 0; n < 20; n++) begin
        @(negedge i_clock);
        if (o_ready) begin
          seen = 1'b1;
          lat  = n;
          chk("t3 rdata", o_rdata, 32'hDEAD);
          break;
        end
        next_cycle();
      end
      chk("t3 read acked", 32'(seen), 32'd1);
      chk("t3 read latency", lat, 32'd3);
    end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0);
    @(negedge i_clock);
    chk("t3 log size", bus_log.size(), 32'd3);
    chk_xfer("t3 w0", 0, 1'b1, 32'h500, 32'hC0);
    chk_xfer("t3 w1", 1, 1'b1, 32'h504, 32'hC1);
    chk_xfer("t3 r", 2, 1'b0, 32'h200, 32'hDEAD);

`ifdef WBUF_FORWARD_EN
    // forwarding returns the youngest matching entry with the bus stalled
    apply_reset();
    next_cycle();
    drive(1'b1, 1'b1, 32'h300, 32'h11);
    next_cycle();
    drive(1'b1, 1'b1, 32'h300, 32'h22);
    next_cycle();
    drive(1'b1, 1'b0, 32'h300, 32'h0);
    @(negedge i_clock);
    chk("t4 fwd ready", 32'(o_ready), 32'd1);
    chk("t4 fwd rdata", o_rdata, 32'h22);
    chk("t4 bus still write", 32'(o_bus_rw), 32'd1);
    next_cycle();
    drain("t4", 40);
    chk("t4 log size", bus_log.size(), 32'd2);
    chk_xfer("t4 w0", 0, 1'b1, 32'h300, 32'h11);
    chk_xfer("t4 w1", 1, 1'b1, 32'h300, 32'h22);
`endif

    // request held high across the ack pulse pushes two distinct entries
    apply_reset();
    next_cycle();
    drive(1'b1, 1'b1, 32'h600, 32'hD0);
    @(negedge i_clock);
    chk("t6 ack0", 32'(o_ready), 32'd1);
    next_cycle();
    drive(1'b1, 1'b1, 32'h604, 32'hD1);
    @(negedge i_clock);
    chk("t6 ack1", 32'(o_ready), 32'd1);
    next_cycle();
    drain("t6", 40);
    chk("t6 log size", bus_log.size(), 32'd2);
    chk_xfer("t6 w0", 0, 1'b1, 32'h600, 32'hD0);
    chk_xfer("t6 w1", 1, 1'b1, 32'h604, 32'hD1);

    // asynchronous reset in the middle of a bus write with entries queued
    apply_reset();
    for (int unsigned i = 0; i < 3; i++) begin
      next_cycle();
      drive(1'b1, 1'b1, 32'h700 + 4*i, 32'hE0 + i);
    end
    next_cycle();
    drive(1'b0, 1'b0, '0, '0);
    @(negedge i_clock);
    chk("t5 in write", 32'(o_bus_request), 32'd1);
    #2;
    i_reset = 1'b0;
    #1;
    chk("t5 bus_req dropped", 32'(o_bus_request), 32'd0);
    chk("t5 bus_addr cleared", o_bus_address, 32'd0);
    chk("t5 empty in reset", 32'(o_empty), 32'd1);
    next_cycle();
    i_reset     = 1'b1;
    i_bus_ready = 1'b1;
    bus_log.delete();
    for (int unsigned i = 0; i < 8; i++) next_cycle();
    @(negedge i_clock);
    chk("t5 empty after", 32'(o_empty), 32'd1);
    chk("t5 no writes", bus_log.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
